tile_sequence_player: RTL and testbench

- Plays a stored tile sequence on the VGA tile grid for the memory game. For each step it draws the selected tile pixel-by-pixel in its colour, holds it, erases it to black, waits a gap, then advances.
- Sits between the random sequence generator / game FSM and the VGA adapter. Drives the adapter's plot, x, y and colour inputs directly.
- Generalises the fixed 2x2 / 8-pixel / 9-step tile lookup to a parametrised grid, tile size and sequence length, with timed playback.

---
 rtl/tile_pkg.sv | 38 +++
 rtl/tile_pixel_walker.sv | 74 +++++++
 rtl/tile_sequence_player.sv | 156 +++++++++++++++
 tb/tb_tile_sequence_player.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared state encoding, constants and width helpers for the tile sequence player.
package tile_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAW,
    ST_HOLD,
    ST_ERASE,
    ST_GAP,
    ST_FIN
  } state_t;

  localparam int unsigned ERASE_COLOUR = 0;
  localparam int unsigned COORD_W      = 8;

  function automatic int unsigned idx_w(input int unsigned grid_bits);
    return 2 * grid_bits;
  endfunction

  function automatic int unsigned len_w(input int unsigned seq_len);
    return $clog2(seq_len + 1);
  endfunction

  function automatic int unsigned pix_w(input int unsigned tile_size);
    return $clog2(tile_size);
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tile_pixel_walker.sv
// Walks every pixel of one tile, row by row, emitting registered plot/x/y/colour.
module tile_pixel_walker
  import tile_pkg::*;
#(
  parameter int unsigned TILE_SIZE = 8,
  parameter int unsigned COL_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               clear,
  input  logic [COORD_W-1:0] ox,
  input  logic [COORD_W-1:0] oy,
  input  logic [COL_W-1:0]   pen,
  output logic               plot,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COL_W-1:0]   colour,
  output logic               last_c
);

  localparam int unsigned PIX_W = pix_w(TILE_SIZE);

  logic [PIX_W-1:0]   px;
  logic [PIX_W-1:0]   py;
  logic [PIX_W-1:0]   px_n;
  logic [PIX_W-1:0]   py_n;
  logic [COORD_W-1:0] ox_q;
  logic [COORD_W-1:0] oy_q;

  // Tile edge is a power of two, so all-ones marks the final column/row.
  assign last_c = plot && (&px) && (&py);
  assign px_n   = px + PIX_W'(1);
  assign py_n   = (&px) ? py + PIX_W'(1) : py;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plot   <= 1'b0;
      px     <= '0;
      py     <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else if (clear) begin
      plot <= 1'b0;
      px   <= '0;
      py   <= '0;
    end else if (go) begin
      plot   <= 1'b1;
      px     <= '0;
      py     <= '0;
      ox_q   <= ox;
      oy_q   <= oy;
      x      <= ox;
      y      <= oy;
      colour <= pen;
    end else if (plot) begin
      if (last_c) begin
        // x/y/colour keep the final pixel once plotting stops
        plot <= 1'b0;
        px   <= '0;
        py   <= '0;
      end else begin
        px <= px_n;
        py <= py_n;
        x  <= ox_q + COORD_W'(px_n);
        y  <= oy_q + COORD_W'(py_n);
      end
    end
  end

endmodule

// File: rtl/tile_sequence_player.sv
// Plays a latched tile sequence: draw, hold, erase and gap for each step, then pulse done.
module tile_sequence_player
  import tile_pkg::*;
#(
  parameter int unsigned SEQ_LEN     = 9,
  parameter int unsigned GRID_BITS   = 1,
  parameter int unsigned TILE_SIZE   = 8,
  parameter int unsigned COL_W       = 3,
  parameter int unsigned HOLD_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 6250000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [SEQ_LEN*idx_w(GRID_BITS)-1:0]  seq,
  input  logic [len_w(SEQ_LEN)-1:0]            length,
  output logic                                 busy,
  output logic                                 done,
  output logic [cnt_w(SEQ_LEN)-1:0]            step,
  output logic                                 plot,
  output logic [7:0]                           x,
  output logic [7:0]                           y,
  output logic [COL_W-1:0]                     colour
);

  localparam int unsigned IDX_W  = idx_w(GRID_BITS);
  localparam int unsigned LEN_W  = len_w(SEQ_LEN);
  localparam int unsigned STEP_W = cnt_w(SEQ_LEN);
  localparam int unsigned PIX_W  = pix_w(TILE_SIZE);
  localparam int unsigned TMR_W  = cnt_w(max_u(HOLD_CYCLES, GAP_CYCLES));

  state_t                   state;
  logic [SEQ_LEN*IDX_W-1:0] seq_q;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         len_clamp_c;
  logic [TMR_W-1:0]         timer;
  logic [IDX_W-1:0]         tile_c;
  logic [IDX_W:0]           tile_p1_c;
  logic [GRID_BITS-1:0]     col_c;
  logic [GRID_BITS-1:0]     row_c;
  logic [7:0]               ox_c;
  logic [7:0]               oy_c;
  logic [COL_W-1:0]         pen_c;
  logic                     go_c;
  logic                     last_c;
  logic                     timer_zero_c;
  logic                     last_step_c;

  assign len_clamp_c = (length > LEN_W'(SEQ_LEN)) ? LEN_W'(SEQ_LEN) : length;

  // Decode of the current step; seq_q and step are stable for the whole step.
  assign tile_c    = seq_q[32'(step) * IDX_W +: IDX_W];
  assign col_c     = tile_c[GRID_BITS-1:0];
  assign row_c     = tile_c[IDX_W-1:GRID_BITS];
  assign ox_c      = 8'({col_c, {PIX_W{1'b0}}});
  assign oy_c      = 8'({row_c, {PIX_W{1'b0}}});
  assign tile_p1_c = {1'b0, tile_c} + {{IDX_W{1'b0}}, 1'b1};
  assign pen_c     = (state == ST_HOLD) ? COL_W'(ERASE_COLOUR) : COL_W'(tile_p1_c);

  assign timer_zero_c = (timer == '0);
  assign last_step_c  = (LEN_W'(step) + LEN_W'(1)) == len_q;

  // The walker starts a draw out of LOAD and an erase out of the last HOLD cycle.
  assign go_c = !abort && ((state == ST_LOAD) || ((state == ST_HOLD) && timer_zero_c));

  tile_pixel_walker #(
    .TILE_SIZE (TILE_SIZE),
    .COL_W     (COL_W)
  ) u_walker (
    .clk    (clk),
    .reset  (reset),
    .go     (go_c),
    .clear  (abort),
    .ox     (ox_c),
    .oy     (oy_c),
    .pen    (pen_c),
    .plot   (plot),
    .x      (x),
    .y      (y),
    .colour (colour),
    .last_c (last_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      step  <= '0;
      seq_q <= '0;
      len_q <= '0;
      timer <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort wins over start; a half-drawn tile is left on screen.
        state <= ST_IDLE;
        busy  <= 1'b0;
        step  <= '0;
        timer <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              seq_q <= seq;
              len_q <= len_clamp_c;
              busy  <= 1'b1;
              if (len_clamp_c == '0) begin
                state <= ST_FIN;
                done  <= 1'b1;
              end else begin
                state <= ST_LOAD;
              end
            end
          end
          ST_LOAD: state <= ST_DRAW;
          ST_DRAW: begin
            if (last_c) begin
              state <= ST_HOLD;
              timer <= TMR_W'(HOLD_CYCLES - 1);
            end
          end
          ST_HOLD: begin
            if (timer_zero_c) state <= ST_ERASE;
            else              timer <= timer - TMR_W'(1);
          end
          ST_ERASE: begin
            if (last_c) begin
              state <= ST_GAP;
              timer <= TMR_W'(GAP_CYCLES - 1);
            end
          end
          ST_GAP: begin
            if (!timer_zero_c) begin
              timer <= timer - TMR_W'(1);
            end else if (last_step_c) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              step  <= step + STEP_W'(1);
              state <= ST_LOAD;
            end
          end
          ST_FIN: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            step  <= '0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tile_sequence_player.sv
// Scoreboard bench: stimulus queues expected pixels, a negedge monitor pops and compares each plot.
module tb_tile_sequence_player;

  localparam int SEQ_LEN   = 9;
  localparam int GRID_BITS = 1;
  localparam int TILE_SIZE = 2;
  localparam int COL_W     = 3;
  localparam int HOLD      = 3;
  localparam int GAP       = 2;

  typedef struct {
    int x;
    int y;
    int c;
    int s;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [17:0] seq;
  logic [3:0]  length;
  logic        busy;
  logic        done;
  logic [3:0]  step;
  logic        plot;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;

  pix_t sb[$];
  pix_t e;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  tile_sequence_player #(
    .SEQ_LEN     (SEQ_LEN),
    .GRID_BITS   (GRID_BITS),
    .TILE_SIZE   (TILE_SIZE),
    .COL_W       (COL_W),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .seq    (seq),
    .length (length),
    .busy   (busy),
    .done   (done),
    .step   (step),
    .plot   (plot),
    .x      (x),
    .y      (y),
    .colour (colour)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every plotted pixel must match the head of the expected queue.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (plot) begin
      if (sb.size() == 0) begin
        check("unexpected_plot", 1, 0);
      end else begin
        e = sb.pop_front();
        check("plot_x", int'(x), e.x);
        check("plot_y", int'(y), e.y);
        check("plot_colour", int'(colour), e.c);
        check("plot_step", int'(step), e.s);
      end
    end
  end

  task automatic push_pix(input int px, input int py, input int c, input int s);
    sb.push_back('{px, py, c, s});
  endtask

  // One full step: draw in colour idx+1, then erase in colour 0.
  task automatic push_step(input int idx, input int k);
    int ox;
    int oy;
    ox = (idx % 2) * TILE_SIZE;
    oy = (idx / 2) * TILE_SIZE;
    for (int ph = 0; ph < 2; ph++)
      for (int py = 0; py < TILE_SIZE; py++)
        for (int px = 0; px < TILE_SIZE; px++)
          push_pix(ox + px, oy + py, (ph == 0) ? ((idx + 1) % 8) : 0, k);
  endtask

  task automatic kick(input logic [17:0] s, input logic [3:0] len);
    @(negedge clk);
    seq    = s;
    length = len;
    start  = 1'b1;
  endtask

  // Counts negedges after the start pulse until done; optionally pokes start/seq mid-run.
  task automatic wait_done(input int budget, input int poke, output int n,
                           output int busy_n, output int plot_n, output int first_plot);
    n = 0; busy_n = 0; plot_n = 0; first_plot = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == poke) begin
        start = 1'b1;
        seq   = ~seq;
      end
      if (busy) busy_n++;
      if (plot) begin
        plot_n++;
        if (first_plot == 0) first_plot = i;
      end
      if (done) begin
        n = i;
        break;
      end
    end
    start = 1'b0;
    if (n == 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] s;
    int n, bn, pn, fp, d0;
    int arr[9];

    reset = 1'b1; start = 1'b0; abort = 1'b0; seq = '0; length = '0;
    repeat (3) @(negedge clk);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_step", int'(step), 0);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_colour", int'(colour), 0);
    reset = 1'b0;

    // Single step, tile 3: origin (2,2), colour 4.
    s = '0; s[1:0] = 2'd3;
    push_pix(2, 2, 4, 0); push_pix(3, 2, 4, 0); push_pix(2, 3, 4, 0); push_pix(3, 3, 4, 0);
    push_pix(2, 2, 0, 0); push_pix(3, 2, 0, 0); push_pix(2, 3, 0, 0); push_pix(3, 3, 0, 0);
    d0 = done_cnt;
    kick(s, 4'd1);
    wait_done(60, 0, n, bn, pn, fp);
    check("t1_done_latency", n, 15);
    check("t1_first_plot", fp, 2);
    check("t1_plots", pn, 8);
    check("t1_busy_cycles", bn, 15);
    @(negedge clk);
    check("t1_busy_after", int'(busy), 0);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_sb_drain", sb.size(), 0);

    // Three steps: tiles 0,1,2.
    s = '0; s[1:0] = 2'd0; s[3:2] = 2'd1; s[5:4] = 2'd2;
    push_step(0, 0); push_step(1, 1); push_step(2, 2);
    d0 = done_cnt;
    kick(s, 4'd3);
    wait_done(100, 0, n, bn, pn, fp);
    check("t2_done_latency", n, 43);
    check("t2_busy_cycles", bn, 43);
    check("t2_plots", pn, 24);
    @(negedge clk);
    check("t2_busy_after", int'(busy), 0);
    check("t2_done_count", done_cnt - d0, 1);
    check("t2_sb_drain", sb.size(), 0);

    // Zero length: straight to FIN.
    d0 = done_cnt;
    kick(18'h2aaaa, 4'd0);
    wait_done(10, 0, n, bn, pn, fp);
    check("t3_done_latency", n, 1);
    check("t3_busy_cycles", bn, 1);
    check("t3_plots", pn, 0);
    @(negedge clk);
    check("t3_busy_after", int'(busy), 0);
    check("t3_done_count", done_cnt - d0, 1);

    // Length 15 clamps to 9; mid-run start and seq changes are ignored.
    arr = '{3, 2, 1, 0, 1, 2, 3, 0, 2};
    s = '0;
    for (int k = 0; k < 9; k++) begin
      s[2*k +: 2] = 2'(arr[k]);
      push_step(arr[k], k);
    end
    d0 = done_cnt;
    kick(s, 4'd15);
    wait_done(200, 40, n, bn, pn, fp);
    check("t4_done_latency", n, 127);
    check("t4_busy_cycles", bn, 127);
    check("t4_plots", pn, 72);
    repeat (3) @(negedge clk);
    check("t4_busy_after", int'(busy), 0);
    check("t4_done_count", done_cnt - d0, 1);
    check("t4_sb_drain", sb.size(), 0);

    // Abort on the 2nd draw cycle of step 1 (tile 3).
    s = '0; s[1:0] = 2'd0; s[3:2] = 2'd3; s[5:4] = 2'd1;
    push_step(0, 0);
    push_pix(2, 2, 4, 1); push_pix(3, 2, 4, 1);
    d0 = done_cnt;
    kick(s, 4'd3);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_plot", int'(plot), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_step", int'(step), 0);
    check("t5_done", int'(done), 0);
    repeat (30) @(negedge clk);
    check("t5_done_count", done_cnt - d0, 0);
    check("t5_sb_drain", sb.size(), 0);
    s = '0; s[1:0] = 2'd2;
    push_step(2, 0);
    kick(s, 4'd1);
    wait_done(60, 0, n, bn, pn, fp);
    check("t5_replay_latency", n, 15);
    @(negedge clk);
    check("t5_replay_drain", sb.size(), 0);

    // Reset on the 2nd erase cycle of tile 1.
    s = '0; s[1:0] = 2'd1;
    push_pix(2, 0, 2, 0); push_pix(3, 0, 2, 0); push_pix(2, 1, 2, 0); push_pix(3, 1, 2, 0);
    push_pix(2, 0, 0, 0); push_pix(3, 0, 0, 0);
    kick(s, 4'd1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    check("t6_plot", int'(plot), 0);
    check("t6_x", int'(x), 0);
    check("t6_y", int'(y), 0);
    check("t6_colour", int'(colour), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_step", int'(step), 0);
    @(negedge clk);
    reset = 1'b0;
    check("t6_sb_drain", sb.size(), 0);
    s = '0; s[1:0] = 2'd3;
    push_step(3, 0);
    kick(s, 4'd1);
    wait_done(60, 0, n, bn, pn, fp);
    check("t6_restart_latency", n, 15);
    @(negedge clk);
    check("t6_restart_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
